serdes_rx_checker: RTL
======================

SERDES_RX_CHECKER -- requirements
Module: serdes_rx_checker

Interface
REQ-001 The module SHALL have the parameter PERIOD, default 256, giving the comma spacing in words, comma included; legal range 4..65536.
REQ-002 The module SHALL have the parameter LOCK_COUNT, default 4, giving the number of consecutive correctly spaced commas needed to lock; legal range 1..15.
REQ-003 The module SHALL have the parameter UNLOCK_ERRS, default 4, giving the errors without an intervening good comma that cause loss of lock; legal range 1..15.
REQ-004 The module SHALL have port clk, input, 1 bit: the RX parallel clock (rx_pclk); it is the only clock.
REQ-005 The module SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The module SHALL have port rx_d, input, 8 bits: received byte (FF_RX_D_7..0).
REQ-007 The module SHALL have port rx_k, input, 1 bit: control-character flag (FF_RX_D_8).
REQ-008 The module SHALL have ports rx_los and rx_lol, inputs, 1 bit each: loss of signal and CDR loss of lock.
REQ-009 The module SHALL have port clr, input, 1 bit: synchronous clear of the statistics counters.
REQ-010 The module SHALL have port locked, output, 1 bit: high while in LOCKED.
REQ-011 The module SHALL have ports data_o, output, 8 bits, and data_valid_o, output, 1 bit: the checked payload byte and its strobe.
REQ-012 The module SHALL have port err_cnt, output, 16 bits: saturating error count.
REQ-013 The module SHALL have port frame_cnt, output, 16 bits: wrapping count of good frames.

Function
REQ-014 The module SHALL treat a comma as rx_k=1 with rx_d=0xBC (K28.5); rx_k=1 with any other rx_d value is an error.
REQ-015 The module SHALL implement the states HUNT, VERIFY and LOCKED, entering HUNT from reset.
REQ-016 The module SHALL keep a word index idx, 0..PERIOD-1, wrapping to 0 after PERIOD-1; a comma is expected when idx==PERIOD-1, and idx becomes 0 on the following word.
REQ-017 In HUNT, a comma SHALL set idx to 0 on the next word, clear good_cnt, set good_cnt to 1 and move to VERIFY; all other words are ignored.
REQ-018 In VERIFY or LOCKED, each of the following SHALL be one error: a comma at idx!=PERIOD-1; a non-comma at idx==PERIOD-1; a bad K character; a data byte other than ref or ref+1 (mod 256, so 0xFF->0x00 is legal).
REQ-019 Every accepted data byte SHALL load ref; the first data byte after entering VERIFY loads ref without being checked.
REQ-020 In VERIFY, any error SHALL move the state to HUNT, and a good comma SHALL increment good_cnt, moving to LOCKED when good_cnt reaches LOCK_COUNT.
REQ-021 In LOCKED, each error SHALL increment bad_cnt, and reaching UNLOCK_ERRS SHALL move the state to HUNT; a good comma clears bad_cnt.
REQ-022 When rx_los or rx_lol is high, the state SHALL be HUNT on the next edge, overriding every other transition; while either input is high, no errors are counted.
REQ-023 The locked output SHALL be registered and equal (state==LOCKED).
REQ-024 data_o and data_valid_o SHALL be registered with 1-cycle latency; data_valid_o=1 only for a non-K word that passes its check while in LOCKED.
REQ-025 err_cnt SHALL count REQ-018 errors in VERIFY and LOCKED and saturate at 0xFFFF.
REQ-026 frame_cnt SHALL increment on each good comma in LOCKED, wrapping 0xFFFF->0.
REQ-027 clr SHALL zero err_cnt and frame_cnt on the next edge; if clr coincides with an event, clear wins and the result is 0.

Reset
REQ-028 Reset SHALL asynchronously force state=HUNT, idx=0, ref=0, good_cnt=0, bad_cnt=0, locked=0, data_o=0x00, data_valid_o=0, err_cnt=0 and frame_cnt=0.
REQ-029 A reset asserted mid-frame SHALL discard all lock state; after release, lock requires LOCK_COUNT fresh commas.

Configuration
REQ-030 When the macro SERDES_RX_CHECKER_STATS_EN is defined, the err_cnt and frame_cnt logic SHALL be present as specified.
REQ-031 When SERDES_RX_CHECKER_STATS_EN is undefined, err_cnt and frame_cnt SHALL be constant 0 and clr ignored; all other behaviour is identical.

Verification (PERIOD=256, LOCK_COUNT=4, UNLOCK_ERRS=4, STATS_EN defined)
REQ-032 The bench SHALL cover clean lock: commas every 256 words, payload 0x10 held then stepping to 0x11 -> locked=1 one cycle after the 4th comma, data_valid_o pulses with data_o=0x10/0x11, err_cnt=0.
REQ-033 The bench SHALL cover early comma in VERIFY: the 3rd comma arrives at idx=100 -> state HUNT, locked stays 0, err_cnt=1.
REQ-034 The bench SHALL cover errors while locked: 3 bad bytes (jump 0x20->0x40) then a good comma -> locked stays 1, err_cnt=3; 4 bad bytes with no comma between them -> locked=0 after the 4th.
REQ-035 The bench SHALL cover payload wrap: while locked, data goes 0xFF->0x00 -> no error, data_valid_o asserted.
REQ-036 The bench SHALL cover link loss: pulse rx_lol for 1 cycle while locked -> locked=0 next cycle, err_cnt unchanged; relock after 4 commas.
REQ-037 The bench SHALL cover saturation and clear: preload to 0xFFFE and inject 3 errors -> err_cnt=0xFFFF; assert clr together with an error -> err_cnt=0, frame_cnt=0.

Source files
------------

// File: rtl/serdes_rx_checker.sv
// serdes_rx_checker: K28.5 comma alignment, ramp-payload checking and link statistics.
// err_cnt/frame_cnt logic is built only when SERDES_RX_CHECKER_STATS_EN is defined.
module serdes_rx_checker #(
  parameter int unsigned PERIOD      = 256,
  parameter int unsigned LOCK_COUNT  = 4,
  parameter int unsigned UNLOCK_ERRS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_d,
  input  logic        rx_k,
  input  logic        rx_los,
  input  logic        rx_lol,
  input  logic        clr,
  output logic        locked,
  output logic [7:0]  data_o,
  output logic        data_valid_o,
  output logic [15:0] err_cnt,
  output logic [15:0] frame_cnt
);

  localparam int unsigned  IdxW       = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [IdxW-1:0] IdxLast = IdxW'(PERIOD - 1);
  localparam logic [3:0]   LockCnt    = 4'(LOCK_COUNT);
  localparam logic [3:0]   UnlockErrs = 4'(UNLOCK_ERRS);
  localparam logic [7:0]   Comma      = 8'hBC;

  typedef enum logic [1:0] {StHunt, StVerify, StLocked} state_e;

  state_e          state_q, state_d;
  logic [IdxW-1:0] idx_q, idx_next;
  logic [7:0]      ref_q;
  logic            ref_vld_q;
  logic [3:0]      good_cnt_q, bad_cnt_q;

  logic is_comma, at_last, link_down, data_ok, word_err;
  logic checking, err, good_comma, data_acc;

  always_comb begin
    is_comma  = rx_k && (rx_d == Comma);
    at_last   = (idx_q == IdxLast);
    link_down = rx_los || rx_lol;
    // The first byte after entering VERIFY only seeds the reference.
    data_ok   = !ref_vld_q || (rx_d == ref_q) || (rx_d == ref_q + 8'd1);
    if (rx_k) word_err = is_comma ? !at_last : 1'b1;
    else      word_err = at_last || !data_ok;
    checking   = (state_q != StHunt) && !link_down;
    err        = checking && word_err;
    good_comma = checking && is_comma && at_last;
    data_acc   = checking && !rx_k && !at_last && data_ok;
    idx_next   = at_last ? '0 : idx_q + IdxW'(1);
  end

  always_comb begin
    state_d = state_q;
    if (link_down) begin
      state_d = StHunt;
    end else begin
      unique case (state_q)
        StHunt: begin
          if (is_comma) state_d = (LockCnt == 4'd1) ? StLocked : StVerify;
        end
        StVerify: begin
          if (word_err) state_d = StHunt;
          else if (good_comma && (good_cnt_q + 4'd1 >= LockCnt)) state_d = StLocked;
        end
        StLocked: begin
          if (word_err && (bad_cnt_q + 4'd1 >= UnlockErrs)) state_d = StHunt;
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StHunt;
      idx_q        <= '0;
      ref_q        <= 8'h00;
      ref_vld_q    <= 1'b0;
      good_cnt_q   <= 4'd0;
      bad_cnt_q    <= 4'd0;
      locked       <= 1'b0;
      data_o       <= 8'h00;
      data_valid_o <= 1'b0;
    end else begin
      state_q      <= state_d;
      locked       <= (state_d == StLocked);
      data_valid_o <= data_acc && (state_q == StLocked);
      if (data_acc && (state_q == StLocked)) data_o <= rx_d;
      if (data_acc) begin
        ref_q     <= rx_d;
        ref_vld_q <= 1'b1;
      end
      if (link_down) begin
        idx_q      <= '0;
        good_cnt_q <= 4'd0;
        bad_cnt_q  <= 4'd0;
        ref_vld_q  <= 1'b0;
      end else if (state_q == StHunt) begin
        if (is_comma) begin
          idx_q      <= '0;
          good_cnt_q <= 4'd1;
          bad_cnt_q  <= 4'd0;
          ref_vld_q  <= 1'b0;
        end
      end else begin
        idx_q <= idx_next;
        if (state_q == StVerify && good_comma) good_cnt_q <= good_cnt_q + 4'd1;
        if (state_q == StLocked) begin
          if (err)             bad_cnt_q <= bad_cnt_q + 4'd1;
          else if (good_comma) bad_cnt_q <= 4'd0;
        end
      end
    end
  end

`ifdef SERDES_RX_CHECKER_STATS_EN
  logic [15:0] err_cnt_q, frame_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q   <= 16'h0000;
      frame_cnt_q <= 16'h0000;
    end else if (clr) begin
      err_cnt_q   <= 16'h0000;
      frame_cnt_q <= 16'h0000;
    end else begin
      if (err && (err_cnt_q != 16'hFFFF)) err_cnt_q <= err_cnt_q + 16'd1;
      if (good_comma && (state_q == StLocked)) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  assign err_cnt   = err_cnt_q;
  assign frame_cnt = frame_cnt_q;
`else
  logic unused_clr;
  assign unused_clr = clr;
  assign err_cnt    = 16'h0000;
  assign frame_cnt  = 16'h0000;
`endif

endmodule
